// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: op codes and sequencer state encoding shared by the stack sequencer.
package stack_seq_pkg;
    localparam logic [2:0] OP_PUSH    = 3'd0;
    localparam logic [2:0] OP_POP     = 3'd1;
    localparam logic [2:0] OP_REPLACE = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_SWAP    = 3'd4;
    localparam logic [2:0] OP_OVER    = 3'd5;
    typedef enum logic [1:0] {ST_IDLE, ST_STEP2, ST_STEP3} state_t;
endpackage

// File: rtl/stack_seq_stack.sv
// stack_seq_stack: single-cycle stack primitive; push writes SP+1, write-top writes SP, q = mem[SP].
module stack_seq_stack #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wait_state,
    input  logic             change,
    input  logic             dec,
    input  logic             update,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    localparam logic [saddr_width-1:0] SP_ONE = {{(saddr_width-1){1'b0}}, 1'b1};
    logic [width-1:0]       mem_q [2**saddr_width];
    logic [saddr_width-1:0] sp_q, sp_d, wr_addr;
    always_comb begin
        sp_d    = sp_q;
        wr_addr = change ? sp_q + SP_ONE : sp_q;
        if (!wait_state && change) sp_d = dec ? sp_q - SP_ONE : sp_q + SP_ONE;
    end
    // empty stack parks SP one below slot 0 so the first push lands at 0
    always_ff @(posedge clk) begin
        if (reset) sp_q <= '1;
        else       sp_q <= sp_d;
    end
    always_ff @(posedge clk) begin
        if (!wait_state && update) mem_q[wr_addr] <= d;
    end
    assign q = mem_q[sp_q];
endmodule

// File: rtl/stack_seq.sv
// stack_seq: expands PUSH/POP/REPLACE/DUP/SWAP/OVER into stack primitives,
// tracking depth and rejecting overflow/underflow.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [2:0]           op_code,
    input  logic [width-1:0]     op_data,
    output logic                 done,
    output logic                 done_err,
    output logic [width-1:0]     done_data,
    output logic [width-1:0]     tos,
    output logic [saddr_width:0] depth,
    output logic                 err_flag,
    input  logic                 err_clr
);
    localparam logic [saddr_width:0] ONE = {{saddr_width{1'b0}}, 1'b1};
    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [width-1:0]     a_q, a_d, b_q, b_d, done_data_q, done_data_d, s_d, q;
    logic [saddr_width:0] depth_q, depth_d;
    logic                 done_q, done_d, done_err_q, done_err_d, err_flag_q, err_flag_d;
    logic                 do_push, do_pop, do_wtop, legal, nz, ge2, full;
    assign nz   = |depth_q;
    assign ge2  = |depth_q[saddr_width:1];
    assign full = depth_q[saddr_width];
    assign legal = (op_code == OP_PUSH) ? !full :
                   (op_code == OP_POP || op_code == OP_REPLACE) ? nz :
                   (op_code == OP_DUP)  ? nz && !full :
                   (op_code == OP_SWAP) ? ge2 :
                   (op_code == OP_OVER) ? ge2 && !full : 1'b0;
    assign op_ready = (state_q == ST_IDLE) && !stall;
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        depth_d     = depth_q;
        done_d      = 1'b0;
        done_err_d  = 1'b0;
        done_data_d = '0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        do_wtop     = 1'b0;
        s_d         = q;
        if (!stall) begin
            case (state_q)
                ST_IDLE: if (op_valid) begin
                    op_d   = op_code;
                    done_d = 1'b1;
                    if (!legal) done_err_d = 1'b1;
                    else case (op_code)
                        OP_PUSH: begin
                            do_push = 1'b1;
                            s_d = op_data;
                            depth_d = depth_q + ONE;
                            done_data_d = op_data;
                        end
                        OP_POP: begin
                            do_pop = 1'b1;
                            depth_d = depth_q - ONE;
                            done_data_d = q;
                        end
                        OP_REPLACE: begin
                            do_wtop = 1'b1;
                            s_d = op_data;
                            done_data_d = op_data;
                        end
                        OP_DUP: begin
                            do_push = 1'b1;
                            depth_d = depth_q + ONE;
                            done_data_d = q;
                        end
                        default: begin
                            do_pop = 1'b1;
                            a_d = q;
                            done_d = 1'b0;
                            state_d = ST_STEP2;
                        end
                    endcase
                end
                ST_STEP2: begin
                    b_d = q;
                    s_d = a_q;
                    do_wtop = (op_q == OP_SWAP);
                    do_push = (op_q != OP_SWAP);
                    state_d = ST_STEP3;
                end
                default: begin
                    do_push = 1'b1;
                    s_d = b_q;
                    depth_d = (op_q == OP_OVER) ? depth_q + ONE : depth_q;
                    done_d = 1'b1;
                    done_data_d = b_q;
                    state_d = ST_IDLE;
                end
            endcase
        end
        err_flag_d = done_err_d | (err_flag_q & ~err_clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            a_q         <= '0;
            b_q         <= '0;
            depth_q     <= '0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            done_data_q <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            depth_q     <= depth_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            done_data_q <= done_data_d;
            err_flag_q  <= err_flag_d;
        end
    end
    stack_seq_stack #(.saddr_width(saddr_width), .width(width)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .wait_state(stall),
        .change    (do_push | do_pop),
        .dec       (do_pop),
        .update    (do_push | do_wtop),
        .d         (s_d),
        .q         (q)
    );
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign done_data = done_data_q;
    assign tos       = q;
    assign depth     = depth_q;
    assign err_flag  = err_flag_q;
endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed checks of stack_seq with an 8-deep, 16-bit stack.
module tb_stack_seq;
    import stack_seq_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, op_valid = 1'b0, err_clr = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [15:0] op_data = 16'h0;
    logic        op_ready, done, done_err, err_flag;
    logic [15:0] done_data, tos;
    logic [3:0]  depth;
    int          n_chk = 0, n_pass = 0, lat;

    stack_seq #(.saddr_width(3), .width(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .done(done), .done_err(done_err),
        .done_data(done_data), .tos(tos), .depth(depth), .err_flag(err_flag), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!done && l < 8) begin
            tick();
            l++;
        end
    endtask

    task automatic do_op(input logic [2:0] c, input logic [15:0] v, output int l);
        op_valid = 1'b1;
        op_code  = c;
        op_data  = v;
        tick();
        op_valid = 1'b0;
        l = 1;
        while (!done && l < 8) begin
            tick();
            l++;
        end
    endtask

    task automatic push_chk(input logic [15:0] v);
        int l;
        do_op(OP_PUSH, v, l);
        check("push_lat", l, 1);
        check("push_ok", done_err, 1'b0);
    endtask

    task automatic pop_chk(input logic [15:0] exp);
        int l;
        do_op(OP_POP, 16'h0, l);
        check("pop_lat", l, 1);
        check("pop_data", done_data, exp);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_depth", depth, 0);
        check("rst_ready", op_ready, 1);
        check("rst_done", done, 0);
        check("rst_err_flag", err_flag, 0);

        push_chk(16'h1111);
        check("push1_data", done_data, 16'h1111);
        push_chk(16'h2222);
        check("push2_tos", tos, 16'h2222);
        check("push2_depth", depth, 2);
        pop_chk(16'h2222);
        check("pop_depth", depth, 1);
        pop_chk(16'h1111);

        push_chk(16'h000A);
        push_chk(16'h000B);
        do_op(OP_SWAP, 16'h0, lat);
        check("swap_lat", lat, 3);
        check("swap_data", done_data, 16'h000A);
        check("swap_tos", tos, 16'h000A);
        check("swap_depth", depth, 2);
        pop_chk(16'h000A);
        pop_chk(16'h000B);

        push_chk(16'h000A);
        push_chk(16'h000B);
        do_op(OP_OVER, 16'h0, lat);
        check("over_lat", lat, 3);
        check("over_depth", depth, 3);
        check("over_tos", tos, 16'h000A);
        pop_chk(16'h000A);
        pop_chk(16'h000B);
        pop_chk(16'h000A);
        check("over_empty", depth, 0);

        push_chk(16'h0005);
        do_op(OP_DUP, 16'h0, lat);
        check("dup_depth", depth, 2);
        check("dup_tos", tos, 16'h0005);
        do_op(OP_REPLACE, 16'h0007, lat);
        check("repl_tos", tos, 16'h0007);
        check("repl_depth", depth, 2);
        pop_chk(16'h0007);
        pop_chk(16'h0005);

        for (int i = 1; i <= 8; i++) push_chk(16'(i));
        check("full_depth", depth, 8);
        do_op(OP_PUSH, 16'h0099, lat);
        check("ovf_err", done_err, 1);
        check("ovf_data", done_data, 0);
        check("ovf_depth", depth, 8);
        check("ovf_flag", err_flag, 1);
        check("ovf_tos", tos, 16'h0008);
        do_op(OP_DUP, 16'h0, lat);
        check("dup_full_err", done_err, 1);
        for (int i = 8; i >= 1; i--) pop_chk(16'(i));
        do_op(OP_POP, 16'h0, lat);
        check("unf_err", done_err, 1);
        check("unf_depth", depth, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err_flag, 0);
        do_op(3'd6, 16'h0, lat);
        check("ill_lat", lat, 1);
        check("ill_err", done_err, 1);
        check("ill_flag", err_flag, 1);

        push_chk(16'h000A);
        push_chk(16'h000B);
        op_valid = 1'b1;
        op_code  = OP_SWAP;
        tick();
        op_valid = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ready", op_ready, 0);
            check("stall_done", done, 0);
        end
        stall = 1'b0;
        wait_done(lat);
        check("stall_lat", lat, 2);
        check("stall_data", done_data, 16'h000A);
        check("stall_depth", depth, 2);
        pop_chk(16'h000A);
        pop_chk(16'h000B);

        push_chk(16'h000A);
        push_chk(16'h000B);
        op_valid = 1'b1;
        op_code  = OP_OVER;
        tick();
        op_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("midrst_depth", depth, 0);
        check("midrst_ready", op_ready, 1);
        check("midrst_done", done, 0);
        tick();
        check("midrst_done2", done, 0);
        push_chk(16'h0003);
        check("midrst_tos", tos, 16'h0003);
        check("midrst_dep1", depth, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
